// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: operand-admission and result handshakes
// between the MAC sequencer and the surrounding datapath.
interface mac_seq_ctrl_if;
    logic i_op_valid;
    logic o_op_ready;
    logic o_stg_valid;
    logic o_acc_first;
    logic o_inhibit;
    logic o_res_valid;
    logic i_res_ready;

    modport master (
        input  i_op_valid,
        input  i_res_ready,
        output o_op_ready,
        output o_stg_valid,
        output o_acc_first,
        output o_inhibit,
        output o_res_valid
    );

    modport slave (
        output i_op_valid,
        output i_res_ready,
        input  o_op_ready,
        input  o_stg_valid,
        input  o_acc_first,
        input  o_inhibit,
        input  o_res_valid
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the 4-stage FloatSD4 MAC pipeline.
// Optional MAC_SEQ_PERF_EN adds stall / job-cycle counters.
module mac_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [4:0]       i_Q_frac,
    input  logic             i_clear,
    mac_seq_ctrl_if.master   bus,
    output logic [4:0]       o_Q_frac,
    output logic             o_busy,
    output logic             o_done
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [15:0]      o_stall_cnt,
    output logic [15:0]      o_job_cyc
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [DEPTH-1:0] tok_q;
    logic [DEPTH-1:0] lst_q;
    logic [4:0]       qf_q;
    logic             done_q;

    logic inhibit;
    logic op_hs;
    logic res_hs;
    logic is_last;
    logic start_ok;

    // result sits at stg4 only when the job's last token arrives there
    assign inhibit  = lst_q[DEPTH-1] & ~bus.i_res_ready;
    assign res_hs   = lst_q[DEPTH-1] & bus.i_res_ready;
    assign op_hs    = bus.i_op_valid & bus.o_op_ready;
    assign is_last  = (cnt_q == len_q - ONE);
    assign start_ok = i_start & (i_len != '0) & ~i_clear;

    assign bus.o_res_valid = lst_q[DEPTH-1];
    assign bus.o_inhibit   = inhibit;
    assign bus.o_op_ready  = (state_q == FEED) & ~inhibit;
    assign bus.o_stg_valid = op_hs;
    assign bus.o_acc_first = op_hs & (cnt_q == '0);

    assign o_Q_frac = qf_q;
    assign o_busy   = (state_q != IDLE);
    assign o_done   = done_q;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next-state: clear overrides every other event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = FEED;
            end
            FEED: begin
                if (res_hs)                state_d = IDLE;
                else if (op_hs && is_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (res_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_clear) state_d = IDLE;
    end

    // job parameters and term counter; Q_frac survives a clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
            qf_q  <= '0;
        end else if (state_q == IDLE && start_ok) begin
            len_q <= i_len;
            cnt_q <= '0;
            qf_q  <= i_Q_frac;
        end else if (op_hs && !i_clear) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    // token / last-term tracker mirroring the pipeline, frozen on stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tok_q <= '0;
            lst_q <= '0;
        end else if (i_clear) begin
            tok_q <= '0;
            lst_q <= '0;
        end else if (!inhibit) begin
            tok_q <= (tok_q << 1) | DEPTH'(op_hs);
            lst_q <= (lst_q << 1) | DEPTH'(op_hs & is_last);
        end
    end

    // done pulses the cycle after the result is taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) done_q <= 1'b0;
        else          done_q <= res_hs & ~i_clear;
    end

`ifdef MAC_SEQ_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] jcyc_q;

    assign o_stall_cnt = stall_q;
    assign o_job_cyc   = jcyc_q;

    // saturating per-job stall and busy-cycle counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
            jcyc_q  <= '0;
        end else if (state_q == IDLE && start_ok) begin
            stall_q <= '0;
            jcyc_q  <= '0;
        end else begin
            if (inhibit && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (o_busy && jcyc_q != 16'hFFFF)   jcyc_q  <= jcyc_q + 16'd1;
        end
    end
`endif

endmodule
